// File: rtl/gcc_pkg.sv
// Shared definitions for the graph colouring checker: FSM state encoding
// and the default parameter values used by the top level.
package gcc_pkg;

    localparam int GCC_DEF_NUM_V   = 11;
    localparam int GCC_DEF_COLOR_W = 2;
    localparam int GCC_DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } gcc_state_e;

endpackage

// File: rtl/gcc_color_rf.sv
// Vertex colour register file: NUM_V entries of COLOR_W bits, one write port
// and two combinational read ports. Out-of-range read addresses return zero.
module gcc_color_rf #(
    parameter int NUM_V   = 11,
    parameter int COLOR_W = 2,
    parameter int VIDX_W  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [VIDX_W-1:0]  wr_addr_i,
    input  logic [COLOR_W-1:0] wr_data_i,
    input  logic [VIDX_W-1:0]  rd_addr_a_i,
    output logic [COLOR_W-1:0] rd_data_a_o,
    input  logic [VIDX_W-1:0]  rd_addr_b_i,
    output logic [COLOR_W-1:0] rd_data_b_o
);

    logic [COLOR_W-1:0] mem_q [NUM_V];

    // Address decode by comparison, so addresses >= NUM_V never hit an entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_V; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_V; i++) begin
                if (wr_en_i && (wr_addr_i == VIDX_W'(i))) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_data_a_o = '0;
        rd_data_b_o = '0;
        for (int i = 0; i < NUM_V; i++) begin
            if (rd_addr_a_i == VIDX_W'(i)) rd_data_a_o = mem_q[i];
            if (rd_addr_b_i == VIDX_W'(i)) rd_data_b_o = mem_q[i];
        end
    end

endmodule

// File: rtl/graph_coloring_checker.sv
// Streams graph edges against stored vertex colours and counts conflicts.
// Optional macro GCC_FIRST_CONFLICT_EN adds capture of the first conflicting edge.
module graph_coloring_checker
    import gcc_pkg::*;
#(
    parameter int  NUM_V   = GCC_DEF_NUM_V,
    parameter int  COLOR_W = GCC_DEF_COLOR_W,
    parameter int  CNT_W   = GCC_DEF_CNT_W,
    localparam int VIDX_W  = (NUM_V > 1) ? $clog2(NUM_V) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               col_wr_en,
    input  logic [VIDX_W-1:0]  col_wr_addr,
    input  logic [COLOR_W-1:0] col_wr_data,
    input  logic               start,
    input  logic               edge_valid,
    output logic               edge_ready,
    input  logic [VIDX_W-1:0]  edge_u,
    input  logic [VIDX_W-1:0]  edge_v,
    input  logic               edge_last,
`ifdef GCC_FIRST_CONFLICT_EN
    output logic               first_cf_valid,
    output logic [VIDX_W-1:0]  first_cf_u,
    output logic [VIDX_W-1:0]  first_cf_v,
`endif
    output logic               done,
    output logic               coloring_ok,
    output logic [CNT_W-1:0]   conflict_cnt,
    output logic               range_err
);

    localparam logic [VIDX_W:0] NUM_V_EXT = (VIDX_W + 1)'(NUM_V);

    gcc_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rerr_q, rerr_d;
    logic               ok_q, ok_d;
    logic [COLOR_W-1:0] colU, colV;
    logic               accept, edgeInRange, wrInRange, colorWrEn, sameColor;

    function automatic logic inRange(input logic [VIDX_W-1:0] idx);
        return {1'b0, idx} < NUM_V_EXT;
    endfunction

    assign accept      = edge_valid && (state_q == CHECK);
    assign edgeInRange = inRange(edge_u) && inRange(edge_v);
    assign wrInRange   = inRange(col_wr_addr);
    assign colorWrEn   = col_wr_en && (state_q == IDLE) && wrInRange;
    assign sameColor   = (colU == colV);

    gcc_color_rf #(
        .NUM_V   (NUM_V),
        .COLOR_W (COLOR_W),
        .VIDX_W  (VIDX_W)
    ) u_color_rf (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (colorWrEn),
        .wr_addr_i   (col_wr_addr),
        .wr_data_i   (col_wr_data),
        .rd_addr_a_i (edge_u),
        .rd_data_a_o (colU),
        .rd_addr_b_i (edge_v),
        .rd_data_b_o (colV)
    );

`ifdef GCC_FIRST_CONFLICT_EN
    logic              cfValid_q, cfValid_d;
    logic [VIDX_W-1:0] cfU_q, cfU_d, cfV_q, cfV_d;

    always_comb begin
        cfValid_d = cfValid_q;
        cfU_d     = cfU_q;
        cfV_d     = cfV_q;
        if ((state_q == IDLE) && start) begin
            cfValid_d = 1'b0;
            cfU_d     = '0;
            cfV_d     = '0;
        end else if (accept && edgeInRange && sameColor && !cfValid_q) begin
            cfValid_d = 1'b1;
            cfU_d     = edge_u;
            cfV_d     = edge_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfValid_q <= 1'b0;
            cfU_q     <= '0;
            cfV_q     <= '0;
        end else begin
            cfValid_q <= cfValid_d;
            cfU_q     <= cfU_d;
            cfV_q     <= cfV_d;
        end
    end

    assign first_cf_valid = cfValid_q;
    assign first_cf_u     = cfU_q;
    assign first_cf_v     = cfV_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rerr_d  = rerr_q;
        ok_d    = ok_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                    rerr_d  = 1'b0;
                    ok_d    = 1'b0;
                end
            end
            CHECK: begin
                if (accept) begin
                    if (!edgeInRange) begin
                        rerr_d = 1'b1;
                    end else if (sameColor && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (edge_last) state_d = DONE;
                end
            end
            DONE: begin
                ok_d    = (cnt_q == '0) && !rerr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rerr_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rerr_q  <= rerr_d;
            ok_q    <= ok_d;
        end
    end

    // The verdict is valid in DONE itself, then held in ok_q through IDLE.
    assign edge_ready   = (state_q == CHECK);
    assign done         = (state_q == DONE);
    assign coloring_ok  = done ? ((cnt_q == '0) && !rerr_q) : ok_q;
    assign conflict_cnt = cnt_q;
    assign range_err    = rerr_q;

endmodule

// File: doc/graph_coloring_checker.md
GRAPH_COLORING_CHECKER -- requirements
Module: graph_coloring_checker

Interface
REQ-001 SHALL have parameter NUM_V, default 11, the number of graph vertices.
REQ-002 SHALL have parameter COLOR_W, default 2, the width of the colour code per vertex.
REQ-003 SHALL have parameter CNT_W, default 8, the width of the conflict counter; VIDX_W = max(1, $clog2(NUM_V)) is derived.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port col_wr_en, input, 1 bit: writes a vertex colour.
REQ-007 SHALL have port col_wr_addr, input, VIDX_W bits: the vertex index to write.
REQ-008 SHALL have port col_wr_data, input, COLOR_W bits: the colour to write.
REQ-009 SHALL have port start, input, 1 bit: begins a check pass.
REQ-010 SHALL have port edge_valid, input, 1 bit: an edge is presented.
REQ-011 SHALL have port edge_ready, output, 1 bit: the block accepts the edge.
REQ-012 SHALL have port edge_u, input, VIDX_W bits: the first endpoint.
REQ-013 SHALL have port edge_v, input, VIDX_W bits: the second endpoint.
REQ-014 SHALL have port edge_last, input, 1 bit: marks the final edge of the pass.
REQ-015 SHALL have port done, output, 1 bit: a one-cycle pulse when the result is valid.
REQ-016 SHALL have port coloring_ok, output, 1 bit: set when the pass found no conflict and no range error.
REQ-017 SHALL have port conflict_cnt, output, CNT_W bits: the number of conflicting edges.
REQ-018 SHALL have port range_err, output, 1 bit: some accepted edge had an endpoint >= NUM_V.

Function
REQ-019 SHALL implement FSM states IDLE, CHECK and DONE.
REQ-020 IDLE -> CHECK SHALL occur on start=1; on that edge the block clears conflict_cnt, range_err and coloring_ok.
REQ-021 CHECK SHALL assert edge_ready=1; IDLE and DONE SHALL drive edge_ready=0.
REQ-022 An edge SHALL be accepted when edge_valid && edge_ready; at most one edge is accepted per cycle.
REQ-023 Accepted edge, both endpoints < NUM_V and colour[u]==colour[v]: conflict_cnt SHALL increment at the next edge, saturating at 2^CNT_W-1.
REQ-024 A self-loop (u==v) SHALL count as a conflict.
REQ-025 Accepted edge with any endpoint >= NUM_V: SHALL set range_err sticky and SHALL NOT change conflict_cnt.
REQ-026 An accepted edge with edge_last=1 SHALL move CHECK -> DONE.
REQ-027 DONE SHALL pulse done=1 for one cycle and SHALL present coloring_ok = (conflict_cnt==0 && !range_err) in the same cycle; DONE -> IDLE unconditionally.
REQ-028 Latency: done SHALL rise exactly 1 cycle after the handshake of the last edge.
REQ-029 conflict_cnt, range_err and coloring_ok SHALL hold their values in IDLE until the next start.
REQ-030 col_wr_en SHALL take effect only in IDLE; it SHALL be ignored in CHECK/DONE; a write to an address >= NUM_V SHALL be dropped.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 start and col_wr_en in the same IDLE cycle: the write SHALL complete, and the pass SHALL use the new colour.
REQ-033 edge_valid=0 cycles in CHECK SHALL stall without state change.

Reset
REQ-034 rst SHALL force IDLE and set edge_ready=0, done=0, coloring_ok=0, conflict_cnt=0, range_err=0, all vertex colours=0, and the capture registers (if present)=0; it takes precedence over all inputs, including mid-pass.

Configuration
REQ-035 With macro GCC_FIRST_CONFLICT_EN defined, the block SHALL add outputs first_cf_valid (1 bit), first_cf_u and first_cf_v (VIDX_W each), which capture the endpoints of the first conflicting edge of a pass, are cleared on start, and hold until the next start.
REQ-036 Without GCC_FIRST_CONFLICT_EN, those ports and their registers SHALL be absent; all other behaviour is identical.

Structure
REQ-037 Package gcc_pkg SHALL hold the FSM state enum (IDLE/CHECK/DONE) and the default parameter constants.
REQ-038 The colour storage SHALL be sub-module gcc_color_rf: NUM_V x COLOR_W registers, 1 write port, 2 combinational read ports.

Verification
REQ-039 Defaults, 11-vertex Mycielski graph (20 edges), proper 4-colouring loaded, 20 edges streamed back-to-back -> done 1 cycle after the last edge, coloring_ok=1, conflict_cnt=0.
REQ-040 Same graph, all colours 0 -> conflict_cnt=20, coloring_ok=0.
REQ-041 One edge (3,12), NUM_V=11 -> range_err=1, conflict_cnt=0, coloring_ok=0.
REQ-042 CNT_W=2, 5 conflicting edges -> conflict_cnt=3 (saturated).
REQ-043 rst asserted after 7 edges of a pass -> next cycle IDLE, all outputs 0; a new pass behaves normally.
REQ-044 Random edge_valid gaps plus col_wr_en during CHECK -> the write is ignored, the result equals the gap-free run; with GCC_FIRST_CONFLICT_EN, first_cf_u/v equal the first conflicting edge.
